rc4_crack_core: RTL and testbench

Parametrised successor of the single-key RC4 brute-force engine: one self-contained cracking core with internal 256x8 S-box state, an external encrypted-message ROM read port and a decrypted-message write port. It iterates candidate keys over a programmable range with core_id/num_cores striding, so N instances split the keyspace. A top level instantiates N cores plus shared ROMs and ORs found.

---
 rtl/rc4_crack_core.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_rc4_crack_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_crack_core.sv
`default_nettype none
// ============================================================================
//  Module   : rc4_crack_core
//  Purpose  : One RC4 brute-force cracking core. It walks candidate keys
//             key_start+core_id, +num_cores, ... up to key_limit. For each
//             key it runs the RC4 key schedule on an internal single-port
//             256x8 S-box, decrypts the message read from an external ROM and
//             writes the plaintext to an external RAM. A key counts as correct
//             when every decrypted byte is a lowercase letter or a space.
//  Ports    : clk, reset_n (async, active low)
//             start/abort            - control (abort has priority)
//             key_start/key_limit    - inclusive search range, sampled on start
//             core_id/num_cores      - offset/stride, sampled on start
//             msg_addr/msg_q         - encrypted ROM port (1-cycle latency)
//             dec_addr/dec_data/dec_we - decrypted RAM write port
//             busy/found/exhausted/key_out/cur_key - status
//  Options  : RC4_EARLY_ABORT_EN - when defined, a key is abandoned right
//             after its first invalid byte has been written.
//  Revision : 1.0 - initial release
// ============================================================================
module rc4_crack_core #(
  parameter int KEY_BITS = 24,
  parameter int MSG_LEN  = 32,
  parameter int CORE_W   = 8,
  localparam int AW      = (MSG_LEN > 2) ? $clog2(MSG_LEN) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [KEY_BITS-1:0] key_start,
  input  logic [KEY_BITS-1:0] key_limit,
  input  logic [CORE_W-1:0]   core_id,
  input  logic [CORE_W-1:0]   num_cores,
  output logic [AW-1:0]       msg_addr,
  input  logic [7:0]          msg_q,
  output logic [AW-1:0]       dec_addr,
  output logic [7:0]          dec_data,
  output logic                dec_we,
  output logic                busy,
  output logic                found,
  output logic                exhausted,
  output logic [KEY_BITS-1:0] key_out,
  output logic [KEY_BITS-1:0] cur_key
);

  localparam int KEY_BYTES = KEY_BITS / 8;
  localparam int KIW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  // Wide enough that key + offset/stride can never wrap, so a carry out of
  // KEY_BITS simply shows up as "greater than key_limit".
  localparam int SW        = ((KEY_BITS > CORE_W) ? KEY_BITS : CORE_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_KSA   = 3'd2,
    S_PRGA  = 3'd3,
    S_NEXT  = 3'd4,
    S_FOUND = 3'd5,
    S_EXH   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          phase_q, phase_d;
  logic [7:0]          i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [AW-1:0]       k_q, k_d;
  logic [KIW-1:0]      kidx_q, kidx_d;
  logic [KEY_BITS-1:0] cur_key_q, cur_key_d, key_lim_q, key_lim_d;
  logic [KEY_BITS-1:0] key_out_q, key_out_d;
  logic [CORE_W-1:0]   stride_q, stride_d;
  logic                valid_q, valid_d, busy_q, busy_d;
  logic                found_q, found_d, exh_q, exh_d, dec_we_q, dec_we_d;
  logic [AW-1:0]       msg_addr_q, msg_addr_d, dec_addr_q, dec_addr_d;
  logic [7:0]          dec_data_q, dec_data_d;

  // S-box: single port, synchronous read, one access per cycle
  logic [7:0]          sbox_mem [256];
  logic [7:0]          sb_rdata_q;
  logic [7:0]          w_sb_addr, w_sb_wdata;
  logic                w_sb_we;

  logic [SW-1:0]       w_first, w_next;
  logic [7:0]          w_kb, w_plain;
  logic                w_ok;

  assign w_first = SW'(key_start) + SW'(core_id);
  assign w_next  = SW'(cur_key_q) + SW'(stride_q);
  assign w_plain = sb_rdata_q ^ msg_q;
  assign w_ok    = ((w_plain >= 8'h61) && (w_plain <= 8'h7A)) || (w_plain == 8'h20);

  // Key byte for this KSA step, most significant byte first
  always_comb begin
    w_kb = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == KIW'(b)) w_kb = cur_key_q[KEY_BITS-1-8*b -: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    k_d        = k_q;
    kidx_d     = kidx_q;
    cur_key_d  = cur_key_q;
    key_lim_d  = key_lim_q;
    key_out_d  = key_out_q;
    stride_d   = stride_q;
    valid_d    = valid_q;
    found_d    = found_q;
    exh_d      = exh_q;
    msg_addr_d = msg_addr_q;
    dec_addr_d = dec_addr_q;
    dec_data_d = dec_data_q;
    dec_we_d   = 1'b0;
    w_sb_addr  = i_q;
    w_sb_wdata = i_q;
    w_sb_we    = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXH: begin
          if (start) begin
            found_d   = 1'b0;
            exh_d     = 1'b0;
            cur_key_d = w_first[KEY_BITS-1:0];
            key_lim_d = key_limit;
            stride_d  = (num_cores == '0) ? CORE_W'(1) : num_cores;
            i_d       = 8'h00;
            if (w_first > SW'(key_limit)) begin
              state_d = S_EXH;
              exh_d   = 1'b1;
            end else begin
              state_d = S_INIT;
            end
          end
        end
        S_INIT: begin
          w_sb_we = 1'b1;
          i_d     = i_q + 8'd1;   // wraps to 0, ready for KSA
          if (i_q == 8'hFF) begin
            state_d = S_KSA;
            j_d     = 8'h00;
            kidx_d  = '0;
            phase_d = 3'd0;
          end
        end
        S_KSA: begin
          case (phase_q)
            3'd0: phase_d = 3'd1;                      // read S[i]
            3'd1: begin                                // S[i] arrives, read S[j']
              si_d      = sb_rdata_q;
              j_d       = j_q + sb_rdata_q + w_kb;
              w_sb_addr = j_q + sb_rdata_q + w_kb;
              phase_d   = 3'd2;
            end
            3'd2: begin                                // S[i] <= S[j]
              w_sb_we    = 1'b1;
              w_sb_wdata = sb_rdata_q;
              phase_d    = 3'd3;
            end
            default: begin                             // S[j] <= old S[i]
              w_sb_we    = 1'b1;
              w_sb_addr  = j_q;
              w_sb_wdata = si_q;
              phase_d    = 3'd0;
              i_d        = i_q + 8'd1;
              kidx_d     = (kidx_q == KIW'(KEY_BYTES-1)) ? '0 : kidx_q + KIW'(1);
              if (i_q == 8'hFF) begin
                state_d = S_PRGA;
                j_d     = 8'h00;
                k_d     = '0;
                valid_d = 1'b1;
              end
            end
          endcase
        end
        S_PRGA: begin
          case (phase_q)
            3'd0: begin                                // i++, read S[i], fetch msg[k]
              i_d        = i_q + 8'd1;
              w_sb_addr  = i_q + 8'd1;
              msg_addr_d = k_q;
              phase_d    = 3'd1;
            end
            3'd1: begin
              si_d      = sb_rdata_q;
              j_d       = j_q + sb_rdata_q;
              w_sb_addr = j_q + sb_rdata_q;
              phase_d   = 3'd2;
            end
            3'd2: begin
              sj_d       = sb_rdata_q;
              w_sb_we    = 1'b1;
              w_sb_wdata = sb_rdata_q;
              phase_d    = 3'd3;
            end
            3'd3: begin
              w_sb_we    = 1'b1;
              w_sb_addr  = j_q;
              w_sb_wdata = si_q;
              phase_d    = 3'd4;
            end
            3'd4: begin                                // read S[S[i]+S[j]]
              w_sb_addr = si_q + sj_q;
              phase_d   = 3'd5;
            end
            default: begin                             // keystream byte ready
              dec_we_d   = 1'b1;
              dec_addr_d = k_q;
              dec_data_d = w_plain;
              valid_d    = valid_q & w_ok;
              phase_d    = 3'd0;
              k_d        = k_q + AW'(1);
`ifdef RC4_EARLY_ABORT_EN
              if ((k_q == AW'(MSG_LEN-1)) || !w_ok) state_d = S_NEXT;
`else
              if (k_q == AW'(MSG_LEN-1)) state_d = S_NEXT;
`endif
            end
          endcase
        end
        S_NEXT: begin
          if (valid_q) begin
            state_d   = S_FOUND;
            found_d   = 1'b1;
            key_out_d = cur_key_q;
          end else if (w_next > SW'(key_lim_q)) begin
            state_d = S_EXH;
            exh_d   = 1'b1;
          end else begin
            cur_key_d = w_next[KEY_BITS-1:0];
            i_d       = 8'h00;
            state_d   = S_INIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_INIT) || (state_d == S_KSA) ||
             (state_d == S_PRGA) || (state_d == S_NEXT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 3'd0;
      i_q        <= 8'h00;
      j_q        <= 8'h00;
      si_q       <= 8'h00;
      sj_q       <= 8'h00;
      k_q        <= '0;
      kidx_q     <= '0;
      cur_key_q  <= '0;
      key_lim_q  <= '0;
      key_out_q  <= '0;
      stride_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      found_q    <= 1'b0;
      exh_q      <= 1'b0;
      dec_we_q   <= 1'b0;
      msg_addr_q <= '0;
      dec_addr_q <= '0;
      dec_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      k_q        <= k_d;
      kidx_q     <= kidx_d;
      cur_key_q  <= cur_key_d;
      key_lim_q  <= key_lim_d;
      key_out_q  <= key_out_d;
      stride_q   <= stride_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      found_q    <= found_d;
      exh_q      <= exh_d;
      dec_we_q   <= dec_we_d;
      msg_addr_q <= msg_addr_d;
      dec_addr_q <= dec_addr_d;
      dec_data_q <= dec_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_sb_we) sbox_mem[w_sb_addr] <= w_sb_wdata;
    sb_rdata_q <= sbox_mem[w_sb_addr];
  end

  assign msg_addr  = msg_addr_q;
  assign dec_addr  = dec_addr_q;
  assign dec_data  = dec_data_q;
  assign dec_we    = dec_we_q;
  assign busy      = busy_q;
  assign found     = found_q;
  assign exhausted = exh_q;
  assign key_out   = key_out_q;
  assign cur_key   = cur_key_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_crack_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rc4_crack_core
//  Purpose  : Scoreboard bench for rc4_crack_core. A reference RC4 computes
//             the ciphertext of "attack at dawn" under key 24'h000042 and the
//             expected plaintext writes/verdict for every search launched.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rc4_crack_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [23:0] key_start = '0, key_limit = '0;
  logic [7:0]  core_id = '0, num_cores = '0;
  logic [4:0]  msg_addr, dec_addr;
  logic [7:0]  msg_q = 8'h00, dec_data;
  logic        dec_we, busy, found, exhausted;
  logic [23:0] key_out, cur_key;

  rc4_crack_core #(.KEY_BITS(24), .MSG_LEN(32), .CORE_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .key_start(key_start), .key_limit(key_limit),
    .core_id(core_id), .num_cores(num_cores),
    .msg_addr(msg_addr), .msg_q(msg_q),
    .dec_addr(dec_addr), .dec_data(dec_data), .dec_we(dec_we),
    .busy(busy), .found(found), .exhausted(exhausted),
    .key_out(key_out), .cur_key(cur_key)
  );

  always #5 clk = ~clk;

  logic [7:0] rom  [32];
  logic [7:0] dram [32];
  logic [7:0] pt   [32];
  logic [7:0] ct   [32];
  logic [7:0] mdl_ks [32];

  always @(posedge clk) msg_q <= rom[msg_addr];
  always @(posedge clk) if (dec_we) dram[dec_addr] <= dec_data;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [12:0] exp_wr_q  [$];   // {addr, data}
  logic [25:0] exp_res_q [$];   // {found, exhausted, key_out}
  logic [23:0] exp_key_out = '0;
  event ev_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_valid(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // Plain RC4: key bytes MSB first, 32 keystream bytes into mdl_ks
  task automatic rc4_gen(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) s[n] = n[7:0];
    j = 8'h00;
    for (int n = 0; n < 256; n++) begin
      j = j + s[n] + kb[n % 3];
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 8'h00; j = 8'h00;
    for (int n = 0; n < 32; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      mdl_ks[n] = s[t];
    end
  endtask

  // Monitor: every plaintext write is matched against the scoreboard
  always @(negedge clk) begin
    if (reset_n && dec_we) begin
      wr_count++;
      if (exp_wr_q.size() == 0) begin
        check("unexpected_dec_we", {51'd0, dec_addr, dec_data}, 64'h1FFF);
      end else begin
        logic [12:0] e;
        e = exp_wr_q.pop_front();
        check("dec_write", {51'd0, dec_addr, dec_data}, {51'd0, e});
      end
    end
  end

  // Monitor: verdict of each search
  always @(ev_done) begin
    logic [25:0] r;
    if (exp_res_q.size() == 0) begin
      check("result_queue_empty", 64'd0, 64'd1);
    end else begin
      r = exp_res_q.pop_front();
      check("found",     {63'd0, found},     {63'd0, r[25]});
      check("exhausted", {63'd0, exhausted}, {63'd0, r[24]});
      check("key_out",   {40'd0, key_out},   {40'd0, r[23:0]});
      check("busy_idle", {63'd0, busy},      64'd0);
    end
    check("writes_pending", 64'(exp_wr_q.size()), 64'd0);
  end

  task automatic pulse_start(input logic [23:0] ks, input logic [23:0] lim,
                             input logic [7:0] cid, input logic [7:0] nc);
    @(negedge clk);
    key_start = ks; key_limit = lim; core_id = cid; num_cores = nc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!((found || exhausted) && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("done_timeout", 64'(n), 64'(budget - 1));
  endtask

  task automatic run_search(input logic [23:0] ks, input logic [23:0] lim,
                            input logic [7:0] cid, input logic [7:0] nc);
    longint key, step;
    bit fnd, ok;
    logic [7:0] p;
    logic [23:0] kout;
    fnd  = 1'b0;
    kout = exp_key_out;
    step = (nc == 0) ? 1 : longint'(nc);
    key  = longint'(ks) + longint'(cid);
    while (key <= longint'(lim) && !fnd) begin
      rc4_gen(key[23:0]);
      ok = 1'b1;
      for (int k = 0; k < 32; k++) begin
        p = mdl_ks[k] ^ ct[k];
        exp_wr_q.push_back({k[4:0], p});
        if (!is_valid(p)) begin
          ok = 1'b0;
`ifdef RC4_EARLY_ABORT_EN
          break;
`endif
        end
      end
      if (ok) begin fnd = 1'b1; kout = key[23:0]; end
      else key += step;
    end
    exp_res_q.push_back({fnd, !fnd, kout});
    exp_key_out = kout;
    pulse_start(ks, lim, cid, nc);
    wait_done(12000);
    -> ev_done;
    @(negedge clk);
  endtask

  initial begin
    logic [8*32-1:0] pt_vec;
    logic [23:0] wk;
    int cnt_exp, cnt0, n;
    pt_vec = {"attack at dawn", {18{8'h20}}};
    for (int k = 0; k < 32; k++) pt[k] = pt_vec[8*(31-k) +: 8];
    rc4_gen(24'h000042);
    for (int k = 0; k < 32; k++) begin
      ct[k]   = mdl_ks[k] ^ pt[k];
      rom[k]  = ct[k];
      dram[k] = 8'h00;
    end

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_found",     {63'd0, found},     64'd0);
    check("rst_exhausted", {63'd0, exhausted}, 64'd0);
    check("rst_dec_we",    {63'd0, dec_we},    64'd0);
    check("rst_key_out",   {40'd0, key_out},   64'd0);
    check("rst_cur_key",   {40'd0, cur_key},   64'd0);
    check("rst_addrs",     {46'd0, msg_addr, dec_addr, dec_data}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single core finds the key; RAM must then hold the plaintext
    run_search(24'h000040, 24'h0000FF, 8'd0, 8'd1);
    for (int k = 0; k < 32; k++) check("dram_plaintext", {56'd0, dram[k]}, {56'd0, pt[k]});

    // Odd half of a 2-core split misses the key, even half finds it
    run_search(24'h000040, 24'h000047, 8'd1, 8'd2);
    run_search(24'h000040, 24'h000047, 8'd0, 8'd2);

    // Top of the keyspace: stride overflows KEY_BITS, must not wrap to 0
    run_search(24'hFFFFFE, 24'hFFFFFF, 8'd0, 8'd4);

    // num_cores = 0 behaves as stride 1
    run_search(24'h000041, 24'h000042, 8'd0, 8'd0);

    // Abort during KSA of key 5, then restart from key_start
    pulse_start(24'h000005, 24'h000005, 8'd0, 8'd1);
    repeat (300) @(negedge clk);
    check("abort_cur_key", {40'd0, cur_key}, 64'h5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    exp_res_q.push_back({1'b0, 1'b0, exp_key_out});
    -> ev_done;
    repeat (5) @(negedge clk);
    check("abort_idle_busy", {63'd0, busy}, 64'd0);
    run_search(24'h000005, 24'h000005, 8'd0, 8'd1);

    // Wrong key whose first byte decrypts invalid: count plaintext writes
    wk = 24'h000050;
    for (int c = 8'h50; c < 256; c++) begin
      rc4_gen(c[23:0]);
      if (!is_valid(mdl_ks[0] ^ ct[0])) begin wk = c[23:0]; break; end
    end
    rc4_gen(wk);
    cnt_exp = 32;
`ifdef RC4_EARLY_ABORT_EN
    for (int k = 0; k < 32; k++) begin
      if (!is_valid(mdl_ks[k] ^ ct[k])) begin cnt_exp = k + 1; break; end
    end
`endif
    cnt0 = wr_count;
    run_search(wk, wk, 8'd0, 8'd1);
    check("wrong_key_dec_we_count", 64'(wr_count - cnt0), 64'(cnt_exp));

    // Asynchronous reset in the middle of PRGA
    rc4_gen(24'h000043);
    for (int k = 0; k < 32; k++) exp_wr_q.push_back({k[4:0], mdl_ks[k] ^ ct[k]});
    pulse_start(24'h000043, 24'h000043, 8'd0, 8'd1);
    n = 0;
    while (!dec_we && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check("prga_timeout", 64'(n), 64'd2999);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy",    {63'd0, busy},   64'd0);
    check("arst_dec_we",  {63'd0, dec_we}, 64'd0);
    check("arst_flags",   {62'd0, found, exhausted}, 64'd0);
    check("arst_keys",    {16'd0, key_out, cur_key}, 64'd0);
    check("arst_ports",   {46'd0, msg_addr, dec_addr, dec_data}, 64'd0);
    exp_wr_q.delete();
    exp_key_out = '0;
    @(negedge clk);
    reset_n = 1'b1;
    cnt0 = wr_count;
    repeat (20) @(negedge clk);
    check("after_reset_no_dec_we", 64'(wr_count - cnt0), 64'd0);

    // Empty range: exhausted at once, nothing decrypted
    cnt0 = wr_count;
    run_search(24'h000010, 24'h00000F, 8'd0, 8'd1);
    check("empty_range_dec_we", 64'(wr_count - cnt0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
